// File: rtl/dpram_wr_ctrl.sv
// dpram_wr_ctrl: producer half of the two-port RAM write/read pair.
// Writes frames of DEPTH words at addresses 0..DEPTH-1 on RAM port A
// (data = frame seed + address, modulo 2^DATA_W). After each frame it
// pulses frame_done, then waits until the reader acknowledges with rd_done.
//
// Handshake: start is a level-sensitive enable. It is sampled only in IDLE,
// and again on the cycle that rd_done is accepted. A frame that has begun
// always runs to completion. rd_done is a single-cycle pulse that counts
// only while the controller sits in WAIT_ACK; at any other time it is
// dropped and never remembered. Each accepted rd_done advances the seed and
// frame_cnt exactly once.
module dpram_wr_ctrl #(
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 8,
  parameter int DEPTH      = 32,
  parameter int DATA_START = 0
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              start,
  input  logic              rd_done,
  output logic              ram_wr_en,
  output logic [ADDR_W-1:0] ram_wr_addr,
  output logic [DATA_W-1:0] ram_wr_data,
  output logic              frame_done,
  output logic              busy,
  output logic [7:0]        frame_cnt,
  output logic [1:0]        dbg_state
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [DATA_W-1:0] SEED_INIT = DATA_W'(DATA_START);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WRITE    = 2'd1,
    WAIT_ACK = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [DATA_W-1:0] seed;
  logic [DATA_W-1:0] seed_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [DATA_W-1:0] data_nxt;
  logic              last_word;
  logic              ack;

  // While in WRITE, ram_wr_addr holds the address being written this cycle,
  // so it doubles as the word counter for the frame.
  assign last_word = (state == WRITE) && (ram_wr_addr == LAST_ADDR);
  assign ack       = (state == WAIT_ACK) && rd_done;
  assign dbg_state = state;

  // Next-state, next-address and next-seed decode.
  always_comb begin
    state_nxt = state;
    addr_nxt  = '0;
    seed_nxt  = seed;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = WRITE;
        end
      end
      WRITE: begin
        if (last_word) begin
          state_nxt = WAIT_ACK;
        end else begin
          addr_nxt = ram_wr_addr + 1'b1;
        end
      end
      WAIT_ACK: begin
        if (rd_done) begin
          seed_nxt  = seed + 1'b1;
          state_nxt = start ? WRITE : IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Write data for the next cycle. The seed used here is the post-ack seed,
  // so a back-to-back frame starts directly from the advanced seed. The
  // bus reads zero whenever no write is in progress.
  always_comb begin
    data_nxt = '0;
    if (state_nxt == WRITE) begin
      data_nxt = seed_nxt + DATA_W'(addr_nxt);
    end
  end

  // State, seed and every output are registered. They are all derived from
  // the next-state decode so that a write becomes visible on the same edge
  // that enters or continues WRITE.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state       <= IDLE;
      seed        <= SEED_INIT;
      ram_wr_en   <= 1'b0;
      ram_wr_addr <= '0;
      ram_wr_data <= '0;
      frame_done  <= 1'b0;
      busy        <= 1'b0;
      frame_cnt   <= 8'd0;
    end else begin
      state       <= state_nxt;
      seed        <= seed_nxt;
      ram_wr_en   <= (state_nxt == WRITE);
      ram_wr_addr <= addr_nxt;
      ram_wr_data <= data_nxt;
      frame_done  <= last_word;
      busy        <= (state_nxt != IDLE);
      if (ack) begin
        frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_dpram_wr_ctrl.sv
// tb_dpram_wr_ctrl: randomized bench for dpram_wr_ctrl. A frame-level
// reference model (seed, acknowledged-frame count, queue of expected words)
// predicts every write and status output.
module tb_dpram_wr_ctrl;

  localparam int ADDR_W     = 5;
  localparam int DATA_W     = 8;
  localparam int DEPTH      = 32;
  localparam int DATA_START = 0;

  // ---------------- clock / reset ----------------
  logic sys_clk = 1'b0;
  logic sys_rst;
  logic start;
  logic rd_done;
  logic              ram_wr_en;
  logic [ADDR_W-1:0] ram_wr_addr;
  logic [DATA_W-1:0] ram_wr_data;
  logic              frame_done;
  logic              busy;
  logic [7:0]        frame_cnt;
  logic [1:0]        dbg_state;

  always #5 sys_clk = ~sys_clk;

  dpram_wr_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .DATA_START(DATA_START)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start), .rd_done(rd_done),
    .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
    .frame_done(frame_done), .busy(busy), .frame_cnt(frame_cnt),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard / model ----------------
  int checks   = 0;
  int failures = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] exp_seed;
  logic [7:0]        exp_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, expv);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance one cycle; inputs and checks happen 1 time unit after the edge.
  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wr_en"}, 32'(ram_wr_en), 32'd0);
    check({tag, "_addr"},  32'(ram_wr_addr), 32'd0);
    check({tag, "_data"},  32'(ram_wr_data), 32'd0);
    check({tag, "_fdone"}, 32'(frame_done), 32'd0);
    check({tag, "_busy"},  32'(busy), 32'd0);
    check({tag, "_cnt"},   32'(frame_cnt), 32'd0);
  endtask

  // Precondition: the first write of a frame is currently visible.
  // Checks the whole frame, waits ack_delay extra cycles in the ack wait,
  // then acknowledges with start = next_start. With noise set, rd_done is
  // toggled randomly during the writes (it must be ignored).
  task automatic run_frame(input int ack_delay, input bit next_start, input bit noise);
    for (int k = 0; k < DEPTH; k++) begin
      exp_q.push_back(DATA_W'((int'(exp_seed) + k) % (1 << DATA_W)));
    end
    for (int k = 0; k < DEPTH; k++) begin
      check("wr_en",     32'(ram_wr_en), 32'd1);
      check("wr_addr",   32'(ram_wr_addr), 32'(k));
      check("wr_data",   32'(ram_wr_data), 32'(exp_q.pop_front()));
      check("fdone_wr",  32'(frame_done), 32'd0);
      check("busy_wr",   32'(busy), 32'd1);
      rd_done = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      start   = 1'($urandom_range(0, 1));
      step();
    end
    check("fdone",       32'(frame_done), 32'd1);
    check("wr_en_fdone", 32'(ram_wr_en), 32'd0);
    check("addr_fdone",  32'(ram_wr_addr), 32'd0);
    check("busy_fdone",  32'(busy), 32'd1);
    check("cnt_fdone",   32'(frame_cnt), 32'(exp_cnt));
    for (int d = 0; d < ack_delay; d++) begin
      rd_done = 1'b0;
      start   = 1'($urandom_range(0, 1));
      step();
      check("fdone_wait", 32'(frame_done), 32'd0);
      check("wr_en_wait", 32'(ram_wr_en), 32'd0);
      check("addr_wait",  32'(ram_wr_addr), 32'd0);
      check("busy_wait",  32'(busy), 32'd1);
      check("cnt_wait",   32'(frame_cnt), 32'(exp_cnt));
    end
    rd_done = 1'b1;
    start   = next_start;
    step();
    rd_done  = 1'b0;
    exp_cnt  = exp_cnt + 8'd1;
    exp_seed = exp_seed + 1'b1;
    check("cnt_ack", 32'(frame_cnt), 32'(exp_cnt));
    if (!next_start) begin
      check("busy_idle",  32'(busy), 32'd0);
      check("wr_en_idle", 32'(ram_wr_en), 32'd0);
      check("fdone_idle", 32'(frame_done), 32'd0);
    end
  endtask

  // From IDLE: raise start for one edge so the first write becomes visible.
  task automatic kick();
    rd_done = 1'b0;
    start   = 1'b1;
    step();
  endtask

  // Idle gap with start low and stray rd_done pulses that must be ignored.
  task automatic idle_gap(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      start   = 1'b0;
      rd_done = 1'($urandom_range(0, 1));
      step();
      check("gap_wr_en", 32'(ram_wr_en), 32'd0);
      check("gap_busy",  32'(busy), 32'd0);
      check("gap_cnt",   32'(frame_cnt), 32'(exp_cnt));
    end
    rd_done = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit nxt;
    bit idle;
    sys_rst  = 1'b1;
    start    = 1'b0;
    rd_done  = 1'b0;
    exp_seed = DATA_W'(DATA_START);
    exp_cnt  = 8'd0;

    // Reset held 10 cycles, then 20 idle cycles with start low.
    for (int i = 0; i < 10; i++) begin
      step();
      check_all_zero("rst");
    end
    sys_rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      rd_done = 1'($urandom_range(0, 1));
      step();
      check_all_zero("idle");
    end
    rd_done = 1'b0;

    // Single frame, ack five cycles after frame_done, back to IDLE.
    kick();
    run_frame(5, 1'b0, 1'b0);

    // Back-to-back frames: ack in the frame_done cycle with start high.
    kick();
    run_frame(0, 1'b1, 1'b0);
    run_frame(0, 1'b1, 1'b0);
    run_frame(0, 1'b0, 1'b0);

    // Stray rd_done during the writes; controller must hold in the ack wait.
    kick();
    run_frame(4, 1'b0, 1'b1);

    // Randomized traffic; enough frames to wrap both seed and frame_cnt.
    idle = 1'b1;
    for (int i = 0; i < 260; i++) begin
      if (idle) begin
        idle_gap($urandom_range(0, 4));
        kick();
      end
      nxt = (i != 259) && ($urandom_range(0, 9) < 7);
      run_frame(($urandom_range(0, 1) != 0) ? 0 : $urandom_range(1, 5),
                nxt, 1'($urandom_range(0, 1)));
      idle = !nxt;
    end

    // Reset mid-frame at address 10: outputs clear without a clock edge.
    kick();
    for (int k = 0; k < 10; k++) begin
      check("pre_rst_addr", 32'(ram_wr_addr), 32'(k));
      step();
    end
    check("pre_rst_addr10", 32'(ram_wr_addr), 32'd10);
    #2;
    sys_rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    step();
    step();
    check_all_zero("rst_hold");
    sys_rst  = 1'b0;
    exp_seed = DATA_W'(DATA_START);
    exp_cnt  = 8'd0;
    exp_q.delete();
    kick();
    run_frame(2, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
